// File: rtl/halfadder_pkg.sv
// rtl/halfadder_pkg.sv - shared constants for the bit-sliced half adder
package halfadder_pkg;

  localparam int HA_MAX_WIDTH = 64;

  // Reset value for the registered sum/carry vectors (sliced to WIDTH by users)
  localparam logic [HA_MAX_WIDTH-1:0] HA_RST_VAL = '0;

endpackage : halfadder_pkg

// File: rtl/halfadder_cell.sv
// rtl/halfadder_cell.sv - single-bit combinational half-adder cell
module halfadder_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule : halfadder_cell

// File: rtl/halfadder_bm.sv
// rtl/halfadder_bm.sv - WIDTH independent half-adder lanes with optional output register
module halfadder_bm
  import halfadder_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c,
  output logic             out_valid
);

  if (WIDTH < 1 || WIDTH > HA_MAX_WIDTH) begin : g_width_check
    $error("halfadder_bm: WIDTH out of range 1..64");
  end

  logic [WIDTH-1:0] s_comb;
  logic [WIDTH-1:0] c_comb;

  // Lanes never see each other's carry; each cell is fully independent
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    halfadder_cell u_cell (
      .a (a[i]),
      .b (b[i]),
      .s (s_comb[i]),
      .c (c_comb[i])
    );
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] s_d, s_q;
    logic [WIDTH-1:0] c_d, c_q;
    logic             out_valid_d, out_valid_q;

    // Data holds on idle cycles; only the valid flag follows in_valid every cycle
    always_comb begin
      s_d         = s_q;
      c_d         = c_q;
      out_valid_d = in_valid;
      if (in_valid) begin
        s_d = s_comb;
        c_d = c_comb;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s_q         <= HA_RST_VAL[WIDTH-1:0];
        c_q         <= HA_RST_VAL[WIDTH-1:0];
        out_valid_q <= 1'b0;
      end else begin
        s_q         <= s_d;
        c_q         <= c_d;
        out_valid_q <= out_valid_d;
      end
    end

    assign s         = s_q;
    assign c         = c_q;
    assign out_valid = out_valid_q;
  end else begin : g_comb
    // Clock and reset are intentionally unused in the stateless variant
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign s         = s_comb;
    assign c         = c_comb;
    assign out_valid = in_valid;
  end

endmodule : halfadder_bm

// File: tb/tb_halfadder_bm.sv
// tb/tb_halfadder_bm.sv - scoreboard bench for registered and combinational half-adder variants
module tb_halfadder_bm;

  typedef struct packed {
    logic [31:0] s;
    logic [31:0] c;
    logic        v;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic        iv1 = 1'b0, a1 = 1'b0, b1 = 1'b0;
  logic        s1r, c1r, ov1r, s1c, c1c, ov1c;
  logic        iv8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, s8, c8;
  logic        ov8;
  logic        iv32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0, s32r, c32r, s32c, c32c;
  logic        ov32r, ov32c;

  halfadder_bm #(.WIDTH(1), .REG_OUT(1'b1)) u_w1r (
    .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1), .s(s1r), .c(c1r), .out_valid(ov1r));
  halfadder_bm #(.WIDTH(1), .REG_OUT(1'b0)) u_w1c (
    .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1), .s(s1c), .c(c1c), .out_valid(ov1c));
  halfadder_bm #(.WIDTH(8), .REG_OUT(1'b1)) u_w8r (
    .clk(clk), .rst(rst), .in_valid(iv8), .a(a8), .b(b8), .s(s8), .c(c8), .out_valid(ov8));
  halfadder_bm #(.WIDTH(32), .REG_OUT(1'b1)) u_w32r (
    .clk(clk), .rst(rst), .in_valid(iv32), .a(a32), .b(b32), .s(s32r), .c(c32r), .out_valid(ov32r));
  halfadder_bm #(.WIDTH(32), .REG_OUT(1'b0)) u_w32c (
    .clk(clk), .rst(rst), .in_valid(iv32), .a(a32), .b(b32), .s(s32c), .c(c32c), .out_valid(ov32c));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    iv8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    iv32 = 1'b1; a32 = '1; b32 = '1;
    tick;
    n_checks++;
    if ({c1r, s1r, ov1r} !== 3'b000) begin
      n_fail++; $display("FAIL reset_w1 got c,s,v=%b%b%b want 000", c1r, s1r, ov1r);
    end
    n_checks++;
    if ({c8, s8, ov8} !== 17'd0) begin
      n_fail++; $display("FAIL reset_w8 got c=%h s=%h v=%b want 00 00 0", c8, s8, ov8);
    end
    n_checks++;
    if ({c32r, s32r, ov32r} !== 65'd0) begin
      n_fail++; $display("FAIL reset_w32 got c=%h s=%h v=%b want 0 0 0", c32r, s32r, ov32r);
    end
    n_checks++;
    if ({c1c, s1c, ov1c} !== 3'b101) begin
      n_fail++; $display("FAIL reset_comb_ignores_rst got c,s,v=%b%b%b want 101", c1c, s1c, ov1c);
    end
  endtask

  task automatic test_exhaustive;
    exp_t       e;
    logic [7:0] tbl = 8'b10_01_01_00;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a1 = k[0]; b1 = k[1]; iv1 = 1'b1;
      e = '0; e.c[0] = tbl[2*k+1]; e.s[0] = tbl[2*k]; e.v = 1'b1;
      sb_q.push_back(e);
      tick;
      e = sb_q.pop_front();
      n_checks++;
      if ({c1r, s1r, ov1r} !== {e.c[0], e.s[0], e.v}) begin
        n_fail++;
        $display("FAIL exhaustive[%0d] got c,s,v=%b%b%b want %b%b%b", k, c1r, s1r, ov1r, e.c[0], e.s[0], e.v);
      end
    end
  endtask

  task automatic test_comb;
    a1 = 1'b1; b1 = 1'b1; iv1 = 1'b1;
    #1;
    n_checks++;
    if ({c1c, s1c, ov1c} !== 3'b101) begin
      n_fail++; $display("FAIL comb_11 got c,s,v=%b%b%b want 101", c1c, s1c, ov1c);
    end
    a1 = 1'b1; b1 = 1'b0;
    #1;
    n_checks++;
    if ({c1c, s1c, ov1c} !== 3'b011) begin
      n_fail++; $display("FAIL comb_10 got c,s,v=%b%b%b want 011", c1c, s1c, ov1c);
    end
    iv1 = 1'b0;
    #1;
    n_checks++;
    if (ov1c !== 1'b0) begin
      n_fail++; $display("FAIL comb_valid got v=%b want 0", ov1c);
    end
  endtask

  task automatic test_lanes;
    exp_t        e;
    logic [47:0] pat [3];
    pat[0] = {8'hF0, 8'hCC, 8'h3C, 8'hC0, 16'h0};
    pat[1] = {8'hAA, 8'h55, 8'hFF, 8'h00, 16'h0};
    pat[2] = {8'hFF, 8'h01, 8'hFE, 8'h01, 16'h0};
    for (int k = 0; k < 3; k++) begin
      a8 = pat[k][47:40]; b8 = pat[k][39:32]; iv8 = 1'b1;
      e = '0; e.s[7:0] = pat[k][31:24]; e.c[7:0] = pat[k][23:16]; e.v = 1'b1;
      sb_q.push_back(e);
      tick;
      e = sb_q.pop_front();
      n_checks++;
      if ({c8, s8, ov8} !== {e.c[7:0], e.s[7:0], e.v}) begin
        n_fail++;
        $display("FAIL lanes[%0d] got c=%h s=%h v=%b want c=%h s=%h v=%b", k, c8, s8, ov8, e.c[7:0], e.s[7:0], e.v);
      end
    end
  endtask

  task automatic test_hold;
    a1 = 1'b1; b1 = 1'b1; iv1 = 1'b1;
    tick;
    n_checks++;
    if ({c1r, s1r, ov1r} !== 3'b101) begin
      n_fail++; $display("FAIL hold_load got c,s,v=%b%b%b want 101", c1r, s1r, ov1r);
    end
    a1 = 1'b0; b1 = 1'b1; iv1 = 1'b0;
    tick;
    n_checks++;
    if ({c1r, s1r, ov1r} !== 3'b100) begin
      n_fail++; $display("FAIL hold_idle got c,s,v=%b%b%b want 100", c1r, s1r, ov1r);
    end
    n_checks++;
    if ({c1c, s1c, ov1c} !== 3'b010) begin
      n_fail++; $display("FAIL hold_comb got c,s,v=%b%b%b want 010", c1c, s1c, ov1c);
    end
  endtask

  task automatic test_reset_midstream;
    a1 = 1'b1; b1 = 1'b1; iv1 = 1'b1; rst = 1'b1;
    tick;
    n_checks++;
    if ({c1r, s1r, ov1r} !== 3'b000) begin
      n_fail++; $display("FAIL midreset_flush got c,s,v=%b%b%b want 000", c1r, s1r, ov1r);
    end
    rst = 1'b0;
    tick;
    n_checks++;
    if ({c1r, s1r, ov1r} !== 3'b101) begin
      n_fail++; $display("FAIL midreset_resume got c,s,v=%b%b%b want 101", c1r, s1r, ov1r);
    end
  endtask

  task automatic test_soak;
    exp_t        e;
    logic [31:0] m_s, m_c;
    iv32 = 1'b0; rst = 1'b1;
    tick;
    rst = 1'b0;
    m_s = '0; m_c = '0;
    for (int n = 0; n < 10000; n++) begin
      a32 = $urandom; b32 = $urandom; iv32 = 1'($urandom_range(0, 1));
      if (iv32) begin
        m_s = a32 ^ b32;
        m_c = a32 & b32;
      end
      e.s = m_s; e.c = m_c; e.v = iv32;
      sb_q.push_back(e);
      #1;
      n_checks++;
      if ({c32c, s32c, ov32c} !== {a32 & b32, a32 ^ b32, iv32}) begin
        n_fail++;
        $display("FAIL soak_comb[%0d] got c=%h s=%h v=%b want c=%h s=%h v=%b",
                 n, c32c, s32c, ov32c, a32 & b32, a32 ^ b32, iv32);
      end
      tick;
      e = sb_q.pop_front();
      n_checks++;
      if ({c32r, s32r, ov32r} !== {e.c, e.s, e.v}) begin
        n_fail++;
        $display("FAIL soak_reg[%0d] got c=%h s=%h v=%b want c=%h s=%h v=%b",
                 n, c32r, s32r, ov32r, e.c, e.s, e.v);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout after %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    tick;
    test_reset;
    test_exhaustive;
    test_comb;
    test_lanes;
    test_hold;
    test_reset_midstream;
    test_soak;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_halfadder_bm

// File: doc/halfadder_bm.md
Name: halfadder_bm

Overview:
Bit-sliced half adder. Each lane i computes sum s[i] = a[i] XOR b[i] and carry c[i] = a[i] AND b[i]. Used as a leaf arithmetic primitive in adder trees and counter increment paths. It has an optional output register stage on a single clock with synchronous active-high reset. With the default WIDTH=1 it is a classic single-bit half adder.

Parameters:
WIDTH, 1, number of independent half-adder lanes; legal range 1..64.
REG_OUT, 1, 1 = outputs registered (1-cycle latency); 0 = outputs purely combinational, and clk/rst have no effect on data.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  qualifies a/b in the current cycle.
a  input  WIDTH  addend A, one bit per lane.
b  input  WIDTH  addend B, one bit per lane.
s  output  WIDTH  per-lane sum (a XOR b).
c  output  WIDTH  per-lane carry (a AND b).
out_valid  output  1  qualifies s/c.

Behaviour:
- Lanes are independent. There is no carry propagation between lanes; c[i] is never fed into lane i+1.
- Truth table per lane (a,b -> c,s): 00->00, 01->01, 10->01, 11->10.
- REG_OUT=1:
  - On each rising clk edge with rst=1: s<=0, c<=0, out_valid<=0. Reset overrides in_valid.
  - On each rising clk edge with rst=0: out_valid<=in_valid. If in_valid=1, s<=a^b and c<=a&b. If in_valid=0, s and c hold their previous values.
  - Latency is exactly 1 cycle; throughput is 1 result per cycle with no bubbles. Back-to-back valids are accepted every cycle.
  - Reset asserted mid-stream discards the in-flight result. The first valid output after rst deasserts is 1 cycle after the first in_valid sampled with rst=0.
- REG_OUT=0:
  - s=a^b and c=a&b continuously, and out_valid=in_valid. Zero latency; glitch behaviour follows the inputs.
  - rst and clk are unused; no state exists.
- Outputs never take X when inputs are known. After reset, s and c are 0 for REG_OUT=1.
- No backpressure: the block has no ready signal, and the downstream consumer must accept every out_valid.

Decomposition:
- Shared package (halfadder_pkg): constant HA_MAX_WIDTH=64 and a localparam for reset value (all-zero).
- Natural sub-module: halfadder_cell. It is a single-bit combinational cell (a, b -> s, c), instantiated WIDTH times in a generate loop.
- The top holds the generate loop, the REG_OUT generate branch, and the output/valid registers.

Test Plan:
- Exhaustive single-bit (WIDTH=1, REG_OUT=1): drive a=0,b=0 at t=0, toggle a every cycle and b every 2 cycles with in_valid=1 -> one cycle later (c,s) = 00, 01, 01, 10 in order, with out_valid=1 each cycle.
- Combinational mode (WIDTH=1, REG_OUT=0): a=1,b=1 -> c=1,s=0 in the same delta. Then a=1,b=0 -> c=0,s=1 with no clock edge.
- Vector lanes (WIDTH=8, REG_OUT=1): a=8'hF0, b=8'hCC, in_valid=1 -> next cycle s=8'h3C, c=8'hC0. Confirm lane independence, with no ripple into adjacent bits.
- Hold on invalid: a valid a=1,b=1 is followed by in_valid=0 with a=0,b=1 -> after the second edge out_valid=0 and s=0,c=1 are held.
- Reset mid-stream: in_valid=1, a=1, b=1 with rst=1 on the same edge -> s=0, c=0, out_valid=0. Next edge with rst=0 and same inputs -> c=1, s=0, out_valid=1.
- Random soak (WIDTH=32, both REG_OUT): 10k random a/b/in_valid -> scoreboard matches a^b and a&b with the correct 1- or 0-cycle alignment.
